// File: rtl/fmrv32im_plic_dispatch.sv
// fmrv32im_plic_dispatch: reads pending/mask from the interrupt controller, presents the lowest unmasked ID, clears it on ack
module fmrv32im_plic_dispatch #(
  parameter logic [3:0] PEND_ADDR = 4'h0,
  parameter logic [3:0] MASK_ADDR = 4'h1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INT_IN,
  output logic        BUS_WE,
  output logic [3:0]  BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  output logic        IRQ_VALID,
  output logic [4:0]  IRQ_ID,
  input  logic        IRQ_ACK,
  output logic [15:0] DISPATCH_CNT
);
  typedef enum logic [2:0] {IDLE, RD_PEND, RD_MASK, SELECT, PRESENT, CLEAR, SETTLE} state_t;
  state_t state, state_nxt;
  logic [31:0] pend, mask, eff;
  logic [4:0] low;
  // lowest set bit of the unmasked pending vector
  always_comb begin
    eff = pend & ~mask;
    low = '0;
    for (int i = 31; i >= 0; i--) if (eff[i]) low = 5'(i);
  end
  // next state and Moore-decoded bus/irq outputs
  always_comb begin
    state_nxt = state;
    BUS_WE = 1'b0;
    BUS_ADDR = PEND_ADDR;
    BUS_WDATA = '0;
    IRQ_VALID = 1'b0;
    case (state)
      IDLE:    state_nxt = INT_IN ? RD_PEND : IDLE;
      RD_PEND: state_nxt = RD_MASK;
      RD_MASK: begin
        BUS_ADDR = MASK_ADDR;
        state_nxt = SELECT;
      end
      SELECT:  state_nxt = (eff == '0) ? IDLE : PRESENT;
      PRESENT: begin
        IRQ_VALID = 1'b1;
        state_nxt = IRQ_ACK ? CLEAR : PRESENT;
      end
      CLEAR: begin
        BUS_WE = 1'b1;
        BUS_WDATA = 32'd1 << IRQ_ID;
        state_nxt = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, captured registers, presented ID and saturating dispatch count
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pend <= '0;
      mask <= '0;
      IRQ_ID <= '0;
      DISPATCH_CNT <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD_PEND) pend <= BUS_RDATA;
      if (state == RD_MASK) mask <= BUS_RDATA;
      if (state == SELECT && eff != '0) IRQ_ID <= low;
      if (state == PRESENT && IRQ_ACK && DISPATCH_CNT != 16'hFFFF) DISPATCH_CNT <= DISPATCH_CNT + 16'd1;
    end
  end
endmodule

// File: tb/tb_fmrv32im_plic_dispatch.sv
// tb_fmrv32im_plic_dispatch: directed checks of read/select/present/clear flow, reset and saturation
module tb_fmrv32im_plic_dispatch;
  logic CLK = 1'b0, RST = 1'b1, INT_IN = 1'b0, IRQ_ACK = 1'b0;
  logic BUS_WE, IRQ_VALID;
  logic [3:0] BUS_ADDR;
  logic [31:0] BUS_WDATA, BUS_RDATA;
  logic [4:0] IRQ_ID;
  logic [15:0] DISPATCH_CNT;
  logic [31:0] pend_v = '0, mask_v = '0;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  assign BUS_RDATA = (BUS_ADDR == 4'h0) ? pend_v : (BUS_ADDR == 4'h1) ? mask_v : 32'hDEAD_BEEF;
  fmrv32im_plic_dispatch dut (
    .CLK(CLK), .RST(RST), .INT_IN(INT_IN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .IRQ_VALID(IRQ_VALID), .IRQ_ID(IRQ_ID),
    .IRQ_ACK(IRQ_ACK), .DISPATCH_CNT(DISPATCH_CNT)
  );
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_bus(input string tag);
    chk({tag, "_we"}, 32'(BUS_WE), 32'd0);
    chk({tag, "_addr"}, 32'(BUS_ADDR), 32'h0);
    chk({tag, "_wdata"}, BUS_WDATA, 32'd0);
  endtask
  task automatic go_present(input logic [31:0] p, input logic [31:0] m, input logic [4:0] eid);
    pend_v = p;
    mask_v = m;
    INT_IN = 1'b1;
    step();
    INT_IN = 1'b0;
    chk("rdpend_addr", 32'(BUS_ADDR), 32'h0);
    chk("rdpend_valid", 32'(IRQ_VALID), 32'd0);
    step();
    chk("rdmask_addr", 32'(BUS_ADDR), 32'h1);
    chk("rdmask_we", 32'(BUS_WE), 32'd0);
    step();
    chk("select_valid", 32'(IRQ_VALID), 32'd0);
    step();
    chk("present_valid", 32'(IRQ_VALID), 32'd1);
    chk("present_id", 32'(IRQ_ID), 32'(eid));
    idle_bus("present");
  endtask
  task automatic ack_clear(input logic [31:0] ewdata, input logic [15:0] ecnt);
    IRQ_ACK = 1'b1;
    step();
    IRQ_ACK = 1'b0;
    chk("clear_we", 32'(BUS_WE), 32'd1);
    chk("clear_addr", 32'(BUS_ADDR), 32'h0);
    chk("clear_wdata", BUS_WDATA, ewdata);
    chk("clear_valid", 32'(IRQ_VALID), 32'd0);
    chk("clear_cnt", 32'(DISPATCH_CNT), 32'(ecnt));
    step();
    idle_bus("settle");
    step();
    idle_bus("idle");
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", 32'(IRQ_VALID), 32'd0);
    chk("rst_id", 32'(IRQ_ID), 32'd0);
    chk("rst_cnt", 32'(DISPATCH_CNT), 32'd0);
    idle_bus("rst");
    RST = 1'b0;
    step();
    idle_bus("idle0");
    go_present(32'h0000_0030, 32'h0, 5'd4);
    ack_clear(32'h0000_0010, 16'd1);
    go_present(32'h8000_0001, 32'h0000_0001, 5'd31);
    ack_clear(32'h8000_0000, 16'd2);
    pend_v = 32'h4;
    mask_v = 32'h4;
    IRQ_ACK = 1'b1;
    INT_IN = 1'b1;
    step();
    INT_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("masked_valid", 32'(IRQ_VALID), 32'd0);
      chk("masked_we", 32'(BUS_WE), 32'd0);
    end
    IRQ_ACK = 1'b0;
    chk("masked_cnt", 32'(DISPATCH_CNT), 32'd2);
    go_present(32'h0000_0006, 32'h0000_0004, 5'd1);
    pend_v = 32'h0000_0001;
    mask_v = 32'h0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("hold_valid", 32'(IRQ_VALID), 32'd1);
      chk("hold_id", 32'(IRQ_ID), 32'd1);
      chk("hold_we", 32'(BUS_WE), 32'd0);
    end
    ack_clear(32'h0000_0002, 16'd3);
    go_present(32'h0000_0100, 32'h0, 5'd8);
    ack_clear(32'h0000_0100, 16'd4);
    go_present(32'h0000_0400, 32'h0, 5'd10);
    ack_clear(32'h0000_0400, 16'd5);
    go_present(32'h0000_0008, 32'h0, 5'd3);
    RST = 1'b1;
    IRQ_ACK = 1'b1;
    step();
    RST = 1'b0;
    IRQ_ACK = 1'b0;
    chk("rstp_valid", 32'(IRQ_VALID), 32'd0);
    chk("rstp_cnt", 32'(DISPATCH_CNT), 32'd0);
    chk("rstp_id", 32'(IRQ_ID), 32'd0);
    idle_bus("rstp");
    step();
    chk("rstp2_valid", 32'(IRQ_VALID), 32'd0);
    idle_bus("rstp2");
    force dut.DISPATCH_CNT = 16'hFFFE;
    #1;
    release dut.DISPATCH_CNT;
    step();
    chk("preload_cnt", 32'(DISPATCH_CNT), 32'h0000_FFFE);
    go_present(32'h0000_0001, 32'h0, 5'd0);
    ack_clear(32'h0000_0001, 16'hFFFF);
    go_present(32'h0000_0002, 32'h0, 5'd1);
    ack_clear(32'h0000_0002, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
